ps2_keycode_tracker: RTL



---
 rtl/ps2_keycode_tracker_pkg.sv | 39 +++
 rtl/ps2_keycode_tracker_if.sv | 17 +
 rtl/ps2_keycode_tracker_rx.sv | 123 ++++++++++++
 rtl/ps2_keycode_tracker.sv | 94 +++++++++
 4 files changed

// File: rtl/ps2_keycode_tracker_pkg.sv
// Shared constants, state encodings and the set-2 to HID lookup for the
// PS/2 keyboard front end.
package ps2_pkg;

  // Set-2 scan codes of interest
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;

  // HID usage codes
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] KEY_NONE  = 8'h00;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {D_NORM, D_BREAK, D_EXT, D_EXT_BREAK} dec_state_t;

  function automatic logic [7:0] set2_to_hid(input logic [7:0] sc);
    case (sc)
      SC_W:     return HID_W;
      SC_A:     return HID_A;
      SC_S:     return HID_S;
      SC_D:     return HID_D;
      SC_SPACE: return HID_SPACE;
      SC_ENTER: return HID_ENTER;
      default:  return KEY_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keycode_tracker_if.sv
// Keyboard-side lines and held-key/status outputs of the keycode tracker.
interface ps2_keycode_tracker_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [7:0] keycode;
  logic [7:0] keycode1;
  logic [7:0] keycode2;
  logic [7:0] scancode;
  logic       frame_valid;
  logic       frame_err;

  // master drives the keyboard lines, slave is the tracker
  modport master (output PS2_CLK, PS2_DAT,
                  input  keycode, keycode1, keycode2, scancode, frame_valid, frame_err);
  modport slave  (input  PS2_CLK, PS2_DAT,
                  output keycode, keycode1, keycode2, scancode, frame_valid, frame_err);
endinterface

// File: rtl/ps2_keycode_tracker_rx.sv
// PS/2 byte receiver: synchronizers, clock glitch filter, falling-edge strobe,
// frame FSM with parity/stop checks and an inactivity timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] data,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] flt_cnt_q;
  logic          strobe, dat_s, timeout;

  rx_state_t     state_q, state_d;
  logic [7:0]    shift_q;
  logic [2:0]    bit_cnt_q;
  logic          par_q;
  logic [TW-1:0] tmo_q;
  logic          shift_en, par_en, load_byte, err;

  // NOTE: synchronizers and filter reset to the idle-high line level so that
  // releasing reset can never fabricate a falling edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge value of the others, which the shift chains rely on.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      dat_sync_q  <= {dat_sync_q[0], ps2_dat};
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q    <= clk_sync_q[1];
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + 1'b1;
      end
    end
  end

  assign strobe  = filt_prev_q & ~filt_q;
  assign dat_s   = dat_sync_q[1];
  // A strobe on the final count wins over the timeout
  assign timeout = (state_q != RX_IDLE) && !strobe && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= RX_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    load_byte = 1'b0;
    err       = 1'b0;
    case (state_q)
      RX_IDLE:   if (strobe && !dat_s) state_d = RX_DATA;
      RX_DATA:   if (strobe) begin
                   shift_en = 1'b1;
                   if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                 end
      RX_PARITY: if (strobe) begin
                   par_en  = 1'b1;
                   state_d = RX_STOP;
                 end
      RX_STOP:   if (strobe) begin
                   if (dat_s && (^{shift_q, par_q})) load_byte = 1'b1;
                   else                              err       = 1'b1;
                   state_d = RX_IDLE;
                 end
      default:   state_d = RX_IDLE;
    endcase
    if (timeout) begin
      state_d = RX_IDLE;
      err     = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      data        <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (strobe || state_q == RX_IDLE) tmo_q <= '0;
      else                              tmo_q <= tmo_q + 1'b1;
      if (state_q == RX_IDLE) bit_cnt_q <= '0;
      if (shift_en) begin
        shift_q   <= {dat_s, shift_q[7:1]};
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end
      if (par_en)    par_q <= dat_s;
      if (load_byte) data  <= shift_q;
      frame_valid <= load_byte;
      frame_err   <= err;
    end
  end

endmodule

// File: rtl/ps2_keycode_tracker.sv
// PS/2 keyboard front end: decodes make/break/extended prefixes and keeps a
// three-slot table of held keys as HID usage codes.
module ps2_keycode_tracker
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 8
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  ps2_keycode_tracker_if.slave  bus
);

  logic [7:0]      rx_data;
  logic            rx_valid, rx_err;
  dec_state_t      dec_q, dec_d;
  logic            ev_make, ev_break, ev_ext, held, placed;
  logic [7:0]      hid;
  logic [2:0][7:0] slot_q, slot_d;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .FILTER_LEN     (FILTER_LEN)
  ) u_rx (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .ps2_clk     (bus.PS2_CLK),
    .ps2_dat     (bus.PS2_DAT),
    .data        (rx_data),
    .frame_valid (rx_valid),
    .frame_err   (rx_err)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dec_q  <= D_NORM;
      slot_q <= '0;
    end else begin
      dec_q  <= dec_d;
      slot_q <= slot_d;
    end
  end

  // Prefix decoder; receive errors deliberately leave the state alone
  always_comb begin
    dec_d    = dec_q;
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = (dec_q == D_EXT) || (dec_q == D_EXT_BREAK);
    if (rx_valid) begin
      case (rx_data)
        SC_EXT:   dec_d = D_EXT;
        SC_BREAK: dec_d = ev_ext ? D_EXT_BREAK : D_BREAK;
        default: begin
          ev_make  = (dec_q == D_NORM)  || (dec_q == D_EXT);
          ev_break = (dec_q == D_BREAK) || (dec_q == D_EXT_BREAK);
          dec_d    = D_NORM;
        end
      endcase
    end
  end

  // Extended keys (including keypad Enter) are not tracked
  assign hid = ev_ext ? KEY_NONE : set2_to_hid(rx_data);

  always_comb begin
    slot_d = slot_q;
    held   = 1'b0;
    placed = 1'b0;
    for (int i = 0; i < 3; i++)
      if (slot_q[i] == hid) held = 1'b1;
    if (hid != KEY_NONE) begin
      if (ev_make && !held) begin
        for (int i = 0; i < 3; i++)
          if (!placed && slot_q[i] == KEY_NONE) begin
            slot_d[i] = hid;
            placed    = 1'b1;
          end
      end
      if (ev_break) begin
        for (int i = 0; i < 3; i++)
          if (slot_q[i] == hid) slot_d[i] = KEY_NONE;
      end
    end
  end

  assign bus.keycode     = slot_q[0];
  assign bus.keycode1    = slot_q[1];
  assign bus.keycode2    = slot_q[2];
  assign bus.scancode    = rx_data;
  assign bus.frame_valid = rx_valid;
  assign bus.frame_err   = rx_err;

endmodule
